id_ex_fwd_stage: RTL and testbench

//   ID/EX pipeline register plus forwarding and load-use hazard control.
//   - Captures decoded operands and control from ID; presents them to EX.
//   - Drives the 2-bit selects of the two EX-stage 32-bit operand muxes (encoding below).
//   - Stalls PC/IF-ID for one cycle on a load-use dependency and inserts a bubble into EX.

---
 rtl/id_ex_fwd_stage.sv | 152 +++++++++++++++
 tb/tb_id_ex_fwd_stage.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_fwd_stage.sv
// ============================================================================
// Module   : id_ex_fwd_stage
// Function : ID/EX pipeline register with EX operand forwarding selects and
//            load-use stall / bubble insertion. Optional: BUBBLE_COUNT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module id_ex_fwd_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               reset,

  input  logic               id_valid,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic [REG_W-1:0]   id_rd,
  input  logic               id_uses_rt,
  input  logic [DATA_W-1:0]  id_rs_data,
  input  logic [DATA_W-1:0]  id_rt_data,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_reg_write,
  input  logic               id_mem_to_reg,
  input  logic [ALUOP_W-1:0] id_alu_op,

  input  logic               flush,

  input  logic               exmem_reg_write,
  input  logic [REG_W-1:0]   exmem_rd,
  input  logic               memwb_reg_write,
  input  logic [REG_W-1:0]   memwb_rd,

  output logic               ex_valid,
  output logic [REG_W-1:0]   ex_rs,
  output logic [REG_W-1:0]   ex_rt,
  output logic [REG_W-1:0]   ex_rd,
  output logic [DATA_W-1:0]  ex_rs_data,
  output logic [DATA_W-1:0]  ex_rt_data,
  output logic [DATA_W-1:0]  ex_imm,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_reg_write,
  output logic               ex_mem_to_reg,
  output logic [ALUOP_W-1:0] ex_alu_op,

  output logic [1:0]         fwd_sel_a,
  output logic [1:0]         fwd_sel_b,
  output logic               stall
`ifdef BUBBLE_COUNT_EN
  ,
  output logic [31:0]        bubble_count
`endif
);

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;

  logic hazard;
  logic bubble;
  logic ctrl_en;

  // Load in EX whose destination is consumed by the instruction now in ID.
  always_comb begin
    hazard = id_valid & ex_valid & ex_mem_read & (ex_rd != '0)
           & ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));
  end

  assign stall   = hazard & ~flush;
  assign bubble  = flush | hazard;
  assign ctrl_en = id_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid      <= 1'b0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd         <= '0;
      ex_rs_data    <= '0;
      ex_rt_data    <= '0;
      ex_imm        <= '0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_op     <= '0;
    end else if (bubble) begin
      ex_valid      <= 1'b0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_rd         <= '0;
      ex_rs_data    <= '0;
      ex_rt_data    <= '0;
      ex_imm        <= '0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_op     <= '0;
    end else begin
      ex_valid      <= id_valid;
      ex_rs         <= id_rs;
      ex_rt         <= id_rt;
      ex_rd         <= id_rd;
      ex_rs_data    <= id_rs_data;
      ex_rt_data    <= id_rt_data;
      ex_imm        <= id_imm;
      // An empty ID slot must never carry side effects into EX.
      ex_mem_read   <= id_mem_read   & ctrl_en;
      ex_mem_write  <= id_mem_write  & ctrl_en;
      ex_reg_write  <= id_reg_write  & ctrl_en;
      ex_mem_to_reg <= id_mem_to_reg & ctrl_en;
      ex_alu_op     <= ctrl_en ? id_alu_op : '0;
    end
  end

  function automatic logic [1:0] fwd_select(input logic [REG_W-1:0] src);
    logic [1:0] sel;
    sel = SEL_RF;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == src))
      sel = SEL_EXMEM;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == src))
      sel = SEL_MEMWB;
    return sel;
  endfunction

  always_comb begin
    fwd_sel_a = SEL_RF;
    fwd_sel_b = SEL_RF;
    if (ex_valid) begin
      fwd_sel_a = fwd_select(ex_rs);
      fwd_sel_b = fwd_select(ex_rt);
    end
  end

`ifdef BUBBLE_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      bubble_count <= 32'd0;
    else if (bubble)
      bubble_count <= bubble_count + 32'd1;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_fwd_stage.sv
// ============================================================================
// Module   : tb_id_ex_fwd_stage
// Function : directed self-checking bench for id_ex_fwd_stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_id_ex_fwd_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_uses_rt;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg;
  logic [3:0]  id_alu_op;
  logic        flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        ex_valid;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic        ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
  logic [3:0]  ex_alu_op;
  logic [1:0]  fwd_sel_a, fwd_sel_b;
  logic        stall;
`ifdef BUBBLE_COUNT_EN
  logic [31:0] bubble_count;
`endif

  int passed = 0;
  int total  = 0;

  id_ex_fwd_stage dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .id_alu_op(id_alu_op),
    .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_op(ex_alu_op),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .stall(stall)
`ifdef BUBBLE_COUNT_EN
    , .bubble_count(bubble_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic urt, input logic [31:0] imm,
                        input logic mr, input logic rw, input logic [3:0] op);
    id_valid      = v;
    id_rs         = rs;
    id_rt         = rt;
    id_rd         = rd;
    id_uses_rt    = urt;
    id_rs_data    = 32'h1000_0000 | {27'd0, rs};
    id_rt_data    = 32'h2000_0000 | {27'd0, rt};
    id_imm        = imm;
    id_mem_read   = mr;
    id_mem_write  = 1'b0;
    id_reg_write  = rw;
    id_mem_to_reg = mr;
    id_alu_op     = op;
  endtask

  task automatic set_wb(input logic ew, input logic [4:0] erd,
                        input logic mw, input logic [4:0] mrd);
    exmem_reg_write = ew;
    exmem_rd        = erd;
    memwb_reg_write = mw;
    memwb_rd        = mrd;
  endtask

  initial begin
    // Reset with random ID inputs, checked before any clock edge.
    reset = 1'b1;
    flush = 1'b0;
    set_id($urandom, 5'($urandom), 5'($urandom), 5'($urandom), $urandom,
           $urandom, $urandom, $urandom, 4'($urandom));
    set_wb(1'b1, 5'($urandom), 1'b1, 5'($urandom));
    #2;
    chk("rst_pre_valid", ex_valid, 0);
    chk("rst_pre_rd", ex_rd, 0);
    chk("rst_pre_rsdata", ex_rs_data, 0);
    chk("rst_pre_memread", ex_mem_read, 0);
    chk("rst_pre_fwda", fwd_sel_a, 0);
    chk("rst_pre_fwdb", fwd_sel_b, 0);
    chk("rst_pre_stall", stall, 0);
    tick();
    chk("rst_edge_valid", ex_valid, 0);
    chk("rst_edge_imm", ex_imm, 0);
    chk("rst_edge_regwrite", ex_reg_write, 0);
    set_wb(1'b0, 5'd0, 1'b0, 5'd0);
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 4'd0);
    reset = 1'b0;

    // Forwarding: add $3 in EX, then sub using $3.
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 32'h0000_00AA, 1'b0, 1'b1, 4'd2);
    tick();
    chk("add_valid", ex_valid, 1);
    chk("add_rd", ex_rd, 3);
    chk("add_rsdata", ex_rs_data, 32'h1000_0001);
    chk("add_imm", ex_imm, 32'h0000_00AA);
    chk("add_regwrite", ex_reg_write, 1);
    chk("add_alu", ex_alu_op, 2);
    chk("add_stall", stall, 0);
    set_id(1'b1, 5'd3, 5'd4, 5'd6, 1'b1, 32'd0, 1'b0, 1'b1, 4'd6);
    tick();
    chk("sub_rs", ex_rs, 3);
    set_wb(1'b1, 5'd3, 1'b0, 5'd0);
    #1;
    chk("fwd_exmem_a", fwd_sel_a, 2'b01);
    chk("fwd_exmem_b", fwd_sel_b, 2'b00);
    set_wb(1'b0, 5'd3, 1'b1, 5'd3);
    #1;
    chk("fwd_memwb_a", fwd_sel_a, 2'b10);
    set_wb(1'b1, 5'd3, 1'b1, 5'd3);
    #1;
    chk("fwd_both_a", fwd_sel_a, 2'b01);
    set_wb(1'b1, 5'd4, 1'b1, 5'd3);
    #1;
    chk("fwd_split_a", fwd_sel_a, 2'b10);
    chk("fwd_split_b", fwd_sel_b, 2'b01);
    set_wb(1'b0, 5'd3, 1'b0, 5'd4);
    #1;
    chk("fwd_nowrite_a", fwd_sel_a, 2'b00);
    set_wb(1'b0, 5'd0, 1'b0, 5'd0);

    // Load-use: lw $5 then add using $5.
    set_id(1'b1, 5'd1, 5'd5, 5'd5, 1'b0, 32'd4, 1'b1, 1'b1, 4'd2);
    tick();
    chk("lw_memread", ex_mem_read, 1);
    set_id(1'b1, 5'd5, 5'd2, 5'd7, 1'b1, 32'd0, 1'b0, 1'b1, 4'd2);
    #1;
    chk("lu_stall", stall, 1);
    tick();
    chk("lu_bubble_valid", ex_valid, 0);
    chk("lu_bubble_memread", ex_mem_read, 0);
    chk("lu_bubble_regwrite", ex_reg_write, 0);
    chk("lu_stall_clear", stall, 0);
`ifdef BUBBLE_COUNT_EN
    chk("cnt_after_lu", bubble_count, 1);
`endif
    set_wb(1'b1, 5'd5, 1'b0, 5'd0);
    tick();
    set_wb(1'b0, 5'd0, 1'b1, 5'd5);
    #1;
    chk("lu_use_valid", ex_valid, 1);
    chk("lu_use_rd", ex_rd, 7);
    chk("lu_use_fwda", fwd_sel_a, 2'b10);
    set_wb(1'b0, 5'd0, 1'b0, 5'd0);

    // Register $0: no stall and no forwarding.
    set_id(1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 32'd8, 1'b1, 1'b1, 4'd2);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 32'd0, 1'b0, 1'b1, 4'd2);
    #1;
    chk("r0_stall", stall, 0);
    tick();
    chk("r0_valid", ex_valid, 1);
    set_wb(1'b1, 5'd0, 1'b1, 5'd0);
    #1;
    chk("r0_fwda", fwd_sel_a, 2'b00);
    chk("r0_fwdb", fwd_sel_b, 2'b00);
    set_wb(1'b0, 5'd0, 1'b0, 5'd0);

    // Hazard and flush in the same cycle.
    set_id(1'b1, 5'd1, 5'd8, 5'd8, 1'b0, 32'd0, 1'b1, 1'b1, 4'd2);
    tick();
    set_id(1'b1, 5'd8, 5'd2, 5'd10, 1'b1, 32'd0, 1'b0, 1'b1, 4'd2);
    flush = 1'b1;
    #1;
    chk("hf_stall", stall, 0);
    tick();
    flush = 1'b0;
    chk("hf_valid", ex_valid, 0);
`ifdef BUBBLE_COUNT_EN
    chk("cnt_after_hf", bubble_count, 2);
`endif

    // Empty ID slot: controls dropped, selects forced to 00.
    set_id(1'b0, 5'd3, 5'd4, 5'd6, 1'b1, 32'd0, 1'b1, 1'b1, 4'd2);
    tick();
    chk("inv_valid", ex_valid, 0);
    chk("inv_rs", ex_rs, 3);
    chk("inv_regwrite", ex_reg_write, 0);
    chk("inv_memread", ex_mem_read, 0);
    set_wb(1'b1, 5'd3, 1'b1, 5'd4);
    #1;
    chk("inv_fwda", fwd_sel_a, 2'b00);
    chk("inv_fwdb", fwd_sel_b, 2'b00);
    set_wb(1'b0, 5'd0, 1'b0, 5'd0);

    // Load to $9 followed by I-type writing $9 (rt not a source), then true use.
    set_id(1'b1, 5'd1, 5'd9, 5'd9, 1'b0, 32'd0, 1'b1, 1'b1, 4'd2);
    tick();
    set_id(1'b1, 5'd1, 5'd9, 5'd9, 1'b0, 32'd5, 1'b0, 1'b1, 4'd2);
    #1;
    chk("itype_nostall", stall, 0);
    id_uses_rt = 1'b1;
    #1;
    chk("rtuse_stall", stall, 1);
    tick();
    chk("rtuse_bubble", ex_valid, 0);
`ifdef BUBBLE_COUNT_EN
    chk("cnt_after_rt", bubble_count, 3);
`endif

    // Asynchronous reset in the middle of a stall.
    set_id(1'b1, 5'd1, 5'd5, 5'd5, 1'b0, 32'd0, 1'b1, 1'b1, 4'd2);
    tick();
    set_id(1'b1, 5'd5, 5'd2, 5'd7, 1'b1, 32'd0, 1'b0, 1'b1, 4'd2);
    #1;
    chk("mid_stall", stall, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", ex_valid, 0);
    chk("mid_rst_rd", ex_rd, 0);
    chk("mid_rst_stall", stall, 0);
`ifdef BUBBLE_COUNT_EN
    chk("mid_rst_cnt", bubble_count, 0);
`endif
    #1;
    reset = 1'b0;
    tick();
    chk("post_rst_valid", ex_valid, 1);
    chk("post_rst_rd", ex_rd, 7);
    chk("post_rst_rs", ex_rs, 5);
`ifdef BUBBLE_COUNT_EN
    chk("post_rst_cnt", bubble_count, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
